// File: rtl/lap_stopwatch.sv
// lap_stopwatch: prescaled up/down stopwatch with one-shot/wrap modes and a show-ahead lap-capture FIFO.
module lap_stopwatch #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX = 99,
   parameter int PRESCALE = 1,
   parameter int LAP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_val,
   input  logic                  dir,
   input  logic                  one_shot,
   input  logic                  lap,
   input  logic                  lap_rd,
   output logic [DATA_WIDTH-1:0] count,
   output logic                  running,
   output logic                  wrap,
   output logic [DATA_WIDTH-1:0] lap_data,
   output logic                  lap_valid,
   output logic                  lap_full,
   output logic                  lap_ovf
);
   localparam int AW = $clog2(LAP_DEPTH);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(MAX);
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
   logic [PW-1:0] presc;
   logic [AW:0] wp, rp;
   logic [DATA_WIDTH-1:0] mem [LAP_DEPTH];
   logic active, tick, term, empty, do_pop, do_push;
   logic [DATA_WIDTH-1:0] next_step;
   always_comb begin
      active = start | running;
      tick = presc == PLAST;
      term = dir ? count == '0 : count >= MAXV;
      next_step = term ? (one_shot ? (dir ? '0 : MAXV) : (dir ? MAXV : '0))
                : dir ? (count > MAXV ? MAXV : count - DATA_WIDTH'(1))
                : count + DATA_WIDTH'(1);
      empty = wp == rp;
      lap_full = wp == {~rp[AW], rp[AW-1:0]};
      lap_valid = ~empty;
      lap_data = empty ? '0 : mem[rp[AW-1:0]];
      do_pop = lap_rd & ~empty & ~clear;
      do_push = lap & ~clear & (~lap_full | do_pop);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         running <= 1'b0;
         wrap <= 1'b0;
         presc <= '0;
         wp <= '0;
         rp <= '0;
         lap_ovf <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clear) begin
            count <= '0;
            running <= 1'b0;
            presc <= '0;
            wp <= '0;
            rp <= '0;
            lap_ovf <= 1'b0;
         end else begin
            if (stop) begin
               running <= 1'b0;
               presc <= '0;
            end else if (load) begin
               count <= load_val > MAXV ? MAXV : load_val;
               presc <= '0;
            end else if (active) begin
               running <= ~(tick & term & one_shot);
               presc <= tick ? '0 : presc + PW'(1);
               if (tick) begin
                  wrap <= term;
                  count <= next_step;
               end
            end
            if (do_pop) rp <= rp + (AW+1)'(1);
            if (do_push) wp <= wp + (AW+1)'(1);
            // a lap is only lost when full and the head is not leaving this cycle
            if (lap & lap_full & ~do_pop) lap_ovf <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= count;
   end
endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: directed scenarios plus randomized stimulus against an integer/queue reference model.
module tb_lap_stopwatch;
   localparam int MAXC = 99;
   localparam int DEPTH = 4;
   logic clk = 0, reset = 1, start = 0, stop = 0, clear = 0, load = 0;
   logic dir = 0, one_shot = 0, lap = 0, lap_rd = 0;
   logic [15:0] load_val = 0;
   logic [15:0] c1, c3, ld1, ld3;
   logic r1, r3, w1, w3, lv1, lv3, lf1, lf3, lo1, lo3;
   int passed = 0, total = 0;
   int m_cnt [2], m_ps [2];
   bit m_run [2], m_wrap [2];
   int q0 [$];
   bit m_ovf;

   lap_stopwatch #(.DATA_WIDTH(16), .MAX(MAXC), .PRESCALE(1), .LAP_DEPTH(DEPTH)) u1 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
      .load_val(load_val), .dir(dir), .one_shot(one_shot), .lap(lap), .lap_rd(lap_rd),
      .count(c1), .running(r1), .wrap(w1), .lap_data(ld1), .lap_valid(lv1), .lap_full(lf1), .lap_ovf(lo1));
   lap_stopwatch #(.DATA_WIDTH(16), .MAX(MAXC), .PRESCALE(3), .LAP_DEPTH(DEPTH)) u3 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
      .load_val(load_val), .dir(dir), .one_shot(one_shot), .lap(lap), .lap_rd(lap_rd),
      .count(c3), .running(r3), .wrap(w3), .lap_data(ld3), .lap_valid(lv3), .lap_full(lf3), .lap_ovf(lo3));

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_ps[i] = 0; m_run[i] = 0; m_wrap[i] = 0;
      end
      q0.delete();
      m_ovf = 0;
   endtask

   task automatic model_step(input int i, input int pres);
      bit terminal;
      m_wrap[i] = 0;
      if (clear) begin
         m_cnt[i] = 0; m_ps[i] = 0; m_run[i] = 0;
      end else if (stop) begin
         m_run[i] = 0; m_ps[i] = 0;
      end else if (load) begin
         m_cnt[i] = int'(load_val) > MAXC ? MAXC : int'(load_val);
         m_ps[i] = 0;
      end else if (start || m_run[i]) begin
         m_run[i] = 1;
         m_ps[i] = (m_ps[i] + 1) % pres;
         if (m_ps[i] == 0) begin
            terminal = dir ? (m_cnt[i] == 0) : (m_cnt[i] == MAXC);
            m_wrap[i] = terminal;
            if (terminal && one_shot) m_run[i] = 0;
            else m_cnt[i] = (m_cnt[i] + (dir ? MAXC : 1)) % (MAXC + 1);
         end
      end
   endtask

   task automatic step();
      int pre;
      bit popped;
      @(posedge clk);
      pre = m_cnt[0];
      model_step(0, 1);
      model_step(1, 3);
      if (clear) begin
         q0.delete();
         m_ovf = 0;
      end else begin
         popped = lap_rd && q0.size() > 0;
         if (popped) void'(q0.pop_front());
         if (lap) begin
            if (q0.size() < DEPTH) q0.push_back(pre);
            else m_ovf = 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (c1 !== 0 || c3 !== 0) $display("FAIL reset_count got %0d/%0d want 0", c1, c3); else passed++;
      total++; if (r1 !== 0 || w1 !== 0 || r3 !== 0 || w3 !== 0) $display("FAIL reset_run_wrap got %b%b%b%b want 0000", r1, w1, r3, w3); else passed++;
      total++; if (lv1 !== 0 || lf1 !== 0 || lo1 !== 0 || ld1 !== 0) $display("FAIL reset_fifo got v%b f%b o%b d%0d want all 0", lv1, lf1, lo1, ld1); else passed++;
      reset = 0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      start = 1; step(); start = 0;
      repeat (36) step();
      total++; if (c1 !== 37) $display("FAIL midrun_pre count got %0d want 37", c1); else passed++;
      #2 reset = 1;
      #1;
      total++; if (c1 !== 0 || r1 !== 0 || w1 !== 0) $display("FAIL midrun_async got c%0d r%b w%b want c0 r0 w0", c1, r1, w1); else passed++;
      repeat (2) @(posedge clk);
      #1;
      total++; if (c1 !== 0 || w1 !== 0 || c3 !== 0 || w3 !== 0) $display("FAIL midrun_hold got c%0d w%b c3 %0d w3 %b want 0", c1, w1, c3, w3); else passed++;
      reset = 0;
      model_reset();
   endtask

   task automatic test_up_wrap();
      dir = 0; one_shot = 0;
      clear = 1; step(); clear = 0;
      start = 1; step(); start = 0;
      total++; if (c1 !== 1 || r1 !== 1) $display("FAIL up_first got c%0d r%b want c1 r1", c1, r1); else passed++;
      repeat (97) step();
      total++; if (c1 !== 98 || w1 !== 0) $display("FAIL up_98 got c%0d w%b want c98 w0", c1, w1); else passed++;
      step();
      total++; if (c1 !== 99 || w1 !== 0) $display("FAIL up_99 got c%0d w%b want c99 w0", c1, w1); else passed++;
      step();
      total++; if (c1 !== 0 || w1 !== 1 || r1 !== 1) $display("FAIL up_wrap got c%0d w%b r%b want c0 w1 r1", c1, w1, r1); else passed++;
      step();
      total++; if (c1 !== 1 || w1 !== 0) $display("FAIL up_after got c%0d w%b want c1 w0", c1, w1); else passed++;
      stop = 1; step(); stop = 0;
   endtask

   task automatic test_down_oneshot();
      int ec;
      clear = 1; step(); clear = 0;
      dir = 1; one_shot = 1; load_val = 2;
      load = 1; step(); load = 0;
      total++; if (c3 !== 2 || r3 !== 0) $display("FAIL down_load got c%0d r%b want c2 r0", c3, r3); else passed++;
      for (int e = 1; e <= 19; e++) begin
         start = (e == 1);
         step();
         ec = e < 3 ? 2 : e < 6 ? 1 : 0;
         total++;
         if (c3 !== 16'(ec) || w3 !== (e == 9) || r3 !== (e < 9))
            $display("FAIL down_edge%0d got c%0d w%b r%b want c%0d w%b r%b", e, c3, w3, r3, ec, e == 9, e < 9);
         else passed++;
      end
      start = 0; dir = 0; one_shot = 0;
   endtask

   task automatic test_priority();
      logic [15:0] saved;
      clear = 1; step(); clear = 0;
      start = 1; step(); start = 0;
      repeat (4) step();
      saved = c1;
      start = 1; stop = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (c1 !== saved || r1 !== 0) $display("FAIL prio_startstop got c%0d r%b want c%0d r0", c1, r1, saved); else passed++;
      end
      start = 0; stop = 0;
      load_val = 150; load = 1; step(); load = 0;
      total++; if (c1 !== 99 || c3 !== 99 || r1 !== 0) $display("FAIL prio_clamp got c%0d c3 %0d r%b want 99 99 r0", c1, c3, r1); else passed++;
      start = 1; step(); start = 0;
      clear = 1; load = 1; start = 1; step(); clear = 0; load = 0; start = 0;
      total++; if (c1 !== 0 || r1 !== 0 || c3 !== 0 || r3 !== 0) $display("FAIL prio_clear got c%0d r%b c3 %0d r3 %b want 0", c1, r1, c3, r3); else passed++;
   endtask

   task automatic test_lap_overflow();
      clear = 1; step(); clear = 0;
      start = 1; step(); start = 0;
      for (int k = 0; k < 30 && c1 < 26; k++) begin
         lap = (c1 % 5 == 0);
         step();
      end
      lap = 0;
      stop = 1; step(); stop = 0;
      total++; if (lf1 !== 1 || lo1 !== 1) $display("FAIL ovf_flags got f%b o%b want f1 o1", lf1, lo1); else passed++;
      for (int j = 0; j < 4; j++) begin
         total++; if (lv1 !== 1 || ld1 !== 16'(5 * (j + 1))) $display("FAIL ovf_read%0d got v%b d%0d want v1 d%0d", j, lv1, ld1, 5 * (j + 1)); else passed++;
         lap_rd = 1; step(); lap_rd = 0;
      end
      total++; if (lv1 !== 0 || ld1 !== 0 || lo1 !== 1) $display("FAIL ovf_empty got v%b d%0d o%b want v0 d0 o1", lv1, ld1, lo1); else passed++;
      clear = 1; step(); clear = 0;
      total++; if (lo1 !== 0) $display("FAIL ovf_clear got %b want 0", lo1); else passed++;
   endtask

   task automatic test_full_pushpop();
      clear = 1; step(); clear = 0;
      for (int v = 11; v <= 14; v++) begin
         load_val = 16'(v); load = 1; step(); load = 0;
         lap = 1; step(); lap = 0;
      end
      total++; if (lf1 !== 1 || ld1 !== 11) $display("FAIL pp_fill got f%b d%0d want f1 d11", lf1, ld1); else passed++;
      load_val = 42; load = 1; step(); load = 0;
      lap = 1; lap_rd = 1; step(); lap = 0; lap_rd = 0;
      total++; if (lf1 !== 1 || lo1 !== 0 || ld1 !== 12) $display("FAIL pp_same got f%b o%b d%0d want f1 o0 d12", lf1, lo1, ld1); else passed++;
      for (int j = 0; j < 4; j++) begin
         total++; if (ld1 !== 16'(j == 3 ? 42 : 12 + j)) $display("FAIL pp_read%0d got %0d want %0d", j, ld1, j == 3 ? 42 : 12 + j); else passed++;
         lap_rd = 1; step(); lap_rd = 0;
      end
      lap = 1; lap_rd = 1; step(); lap = 0; lap_rd = 0;
      total++; if (lv1 !== 1 || ld1 !== 42 || lo1 !== 0) $display("FAIL pp_empty_both got v%b d%0d o%b want v1 d42 o0", lv1, ld1, lo1); else passed++;
   endtask

   task automatic test_random();
      int bad = 0;
      clear = 1; step(); clear = 0;
      for (int k = 0; k < 3000; k++) begin
         clear = $urandom_range(0, 99) < 2;
         stop = $urandom_range(0, 99) < 4;
         load = $urandom_range(0, 99) < 4;
         start = $urandom_range(0, 99) < 15;
         lap = $urandom_range(0, 99) < 20;
         lap_rd = $urandom_range(0, 99) < 20;
         load_val = 16'($urandom_range(0, 200));
         if ($urandom_range(0, 99) < 3) dir = ~dir;
         if ($urandom_range(0, 99) < 3) one_shot = ~one_shot;
         step();
         total++;
         if (c1 !== 16'(m_cnt[0]) || r1 !== m_run[0] || w1 !== m_wrap[0] ||
             c3 !== 16'(m_cnt[1]) || r3 !== m_run[1] || w3 !== m_wrap[1] ||
             lv1 !== (q0.size() > 0) || lf1 !== (q0.size() == DEPTH) || lo1 !== m_ovf ||
             ld1 !== (q0.size() > 0 ? 16'(q0[0]) : 16'd0)) begin
            if (bad < 10)
               $display("FAIL rand_cycle%0d got c%0d r%b w%b c3 %0d r3 %b w3 %b v%b f%b o%b d%0d want c%0d r%b w%b c3 %0d r3 %b w3 %b n%0d o%b d%0d",
                        k, c1, r1, w1, c3, r3, w3, lv1, lf1, lo1, ld1, m_cnt[0], m_run[0], m_wrap[0],
                        m_cnt[1], m_run[1], m_wrap[1], q0.size(), m_ovf, q0.size() > 0 ? q0[0] : 0);
            bad++;
         end else passed++;
      end
      {clear, stop, load, start, lap, lap_rd} = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_reset_mid_run();
      test_up_wrap();
      test_down_oneshot();
      test_priority();
      test_lap_overflow();
      test_full_pushpop();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
- Parametrised successor of the single-channel stopwatch counter.
- Adds:
  - a tick prescaler
  - up/down counting
  - one-shot or wrapping mode
  - synchronous clear and preload
  - a wrap/terminal pulse
  - a lap-capture FIFO read with a show-ahead handshake
- Sits between the control/register block (start/stop/lap strobes) and display/readout logic.

Parameters:
- DATA_WIDTH, 16: width of count, load_val and lap_data.
- MAX, 99: terminal value. Count range is 0..MAX. Requires MAX < 2**DATA_WIDTH.
- PRESCALE, 1: clock cycles per count step. Must be >= 1; 1 means step every active cycle.
- LAP_DEPTH, 4: lap FIFO entries. Power of 2, >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high; clears all state immediately.
- start  in  1  begin/continue counting; level or pulse.
- stop  in  1  halt counting, hold count.
- clear  in  1  synchronous clear of count, prescaler, run state, lap FIFO, overflow flag.
- load  in  1  synchronous preload of count from load_val.
- load_val  in  DATA_WIDTH  preload value.
- dir  in  1  0 = count up, 1 = count down; sampled every cycle.
- one_shot  in  1  1 = halt at terminal instead of wrapping; sampled every cycle.
- lap  in  1  capture current count into lap FIFO.
- lap_rd  in  1  pop lap FIFO head; ignored when lap_valid = 0.
- count  out  DATA_WIDTH  current count (register).
- running  out  1  run state (register).
- wrap  out  1  one-cycle pulse coincident with the wrapped/terminal count value.
- lap_data  out  DATA_WIDTH  FIFO head, show-ahead; 0 when empty.
- lap_valid  out  1  FIFO non-empty.
- lap_full  out  1  FIFO holds LAP_DEPTH entries.
- lap_ovf  out  1  sticky: a lap was dropped because the FIFO was full.

Behaviour:
- Reset (async): count = 0, running = 0, wrap = 0, prescaler = 0, FIFO empty, lap_data = 0, lap_valid = 0, lap_full = 0, lap_ovf = 0. Reset mid-count aborts immediately; no output glitches after release.
- Control priority per edge is clear > stop > load > (start | running).
  - clear: count = 0, prescaler = 0, running = 0, FIFO flushed, lap_ovf = 0. lap and lap_rd are ignored this cycle.
  - stop: running = 0, count held, prescaler = 0.
  - load: count = min(load_val, MAX), prescaler = 0, running unchanged, no step this cycle.
  - Otherwise, active = start | running.
- When active: running = 1 and the prescaler increments; tick = (prescaler == PRESCALE-1), and the prescaler returns to 0 on tick.
- The count steps only on tick. With PRESCALE = 1, start asserted at edge N gives count = 1 after edge N (no idle cycle).
- Up (dir = 0):
  - count < MAX: count + 1.
  - count == MAX, one_shot = 0: count = 0, wrap = 1.
  - count == MAX, one_shot = 1: count stays MAX, running = 0, wrap = 1.
- Down (dir = 1):
  - count > 0: count - 1.
  - count == 0, one_shot = 0: count = MAX, wrap = 1.
  - count == 0, one_shot = 1: count stays 0, running = 0, wrap = 1.
- Out-of-range count: if dir flips while count is out of range, or after a clamped load, the arithmetic stays within 0..MAX; there is no arithmetic beyond MAX.
- wrap is registered and high for exactly the cycle after the terminal tick edge; it is 0 on every other cycle.
- Lap push: on lap (not clear), the value written is the count visible during that cycle, i.e. the pre-update value.
  - Push when full and no simultaneous pop: entry dropped, lap_ovf = 1 until clear/reset.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Push and pop in the same cycle when empty: push only; the pop is ignored.
- Lap pop: on lap_rd with lap_valid = 1, the head advances and lap_data shows the next entry on the following cycle.
- Lap FIFO occupancy is tracked with wrap-bit pointers.
- Simultaneous start and stop: stop wins. start while running has no effect.

Test Plan:
- Reset mid-run:
  - Setup: PRESCALE = 1, MAX = 99; start pulse at edge 0; count to 37; assert reset asynchronously mid-cycle.
  - Required: count = 0 and running = 0 before the next edge; no wrap pulse.
- Up wrap:
  - Setup: MAX = 99, PRESCALE = 1, dir = 0, one_shot = 0; run from 0.
  - Required: 98, 99, 0 sequence; wrap high exactly on the cycle count = 0; running stays 1.
- Down one-shot with prescaler:
  - Setup: PRESCALE = 3, dir = 1, one_shot = 1; load 2, then start.
  - Required: count changes 2 -> 1 -> 0 every 3 cycles; wrap pulses once when count = 0; running = 0; count held at 0 for 10 further cycles.
- Control priority:
  - Hold start and stop high together: count held and running = 0.
  - load_val = 150 with MAX = 99: count = 99.
  - clear with load and start asserted: count = 0, running = 0.
- Lap FIFO overflow:
  - Setup: LAP_DEPTH = 4; lap at counts 5, 10, 15, 20, 25 with no reads.
  - Required: lap_full = 1, lap_ovf = 1.
  - Read back with lap_rd: 5, 10, 15, 20 in order; then lap_valid = 0.
  - clear clears lap_ovf.
- Full FIFO, same-cycle push/pop: with the FIFO full, assert lap and lap_rd together at count 42 → head advances, 42 appended last, lap_ovf stays 0, lap_full stays 1.
